// File: rtl/sw_debounce_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_filter_if
//  Description : Signal bundle between the raw slide-switch pins and the
//                debounced switch consumer.
//                  sw_in    - raw, asynchronous switch vector (into filter)
//                  sw_out   - debounced, registered switch vector
//                  sw_valid - one-cycle strobe on every sw_out update
//                  busy     - a candidate value is being qualified
//                The slave modport is the filter; the master modport is
//                whatever drives the pins and consumes the clean vector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sw_debounce_filter_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic             sw_valid;
    logic             busy;

    modport slave (
        input  sw_in,
        output sw_out,
        output sw_valid,
        output busy
    );

    modport master (
        output sw_in,
        input  sw_out,
        input  sw_valid,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/sw_debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_filter
//  Description : Two-flop synchronizer followed by a whole-vector stability
//                filter for the slide-switch bus. A new switch code is only
//                accepted once it has been held unchanged for STABLE_CYCLES
//                clock cycles; acceptance is announced by a one-cycle
//                sw_valid strobe aligned with the new sw_out value.
//
//  Ports       : clk          - system clock
//                rst          - synchronous, active-high reset
//                bus.sw_in    - raw switch pins (asynchronous to clk)
//                bus.sw_out   - debounced switch vector (registered)
//                bus.sw_valid - one-cycle strobe after each sw_out update
//                bus.busy     - high while a candidate is being qualified
//
//  Parameters  : WIDTH         - number of switch bits
//                STABLE_CYCLES - hold time for acceptance, must be >= 2
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_filter #(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sw_debounce_filter_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter only ever reaches STABLE_CYCLES-1, so $clog2 bits suffice.
    localparam int                 c_CNT_W   = (STABLE_CYCLES > 2) ?
                                               $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_s1;
    logic [WIDTH-1:0]   r_s2;
    state_t             r_state;
    logic [WIDTH-1:0]   r_cand;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sw_out;
    logic               r_sw_valid;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_cand_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_sw_out_nxt;
    logic               w_sw_valid_nxt;

    // ------------------------------------------------------------------------
    // Synchronizer: r_s1 may go metastable; only r_s2 feeds the filter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.sw_in;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Filter state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_STABLE;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_sw_out   <= '0;
            r_sw_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cand     <= w_cand_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sw_out   <= w_sw_out_nxt;
            r_sw_valid <= w_sw_valid_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Filter next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand;
        w_cnt_nxt      = r_cnt;
        w_sw_out_nxt   = r_sw_out;
        w_sw_valid_nxt = 1'b0;

        case (r_state)
            ST_STABLE: begin
                if (r_s2 != r_sw_out) begin
                    w_state_nxt = ST_WAIT;
                    w_cand_nxt  = r_s2;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WAIT: begin
                // Priority matters: a bounce back to the accepted code wins
                // over everything, then a different code restarts the count,
                // and only an unchanged candidate can mature.
                if (r_s2 == r_sw_out) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_s2 != r_cand) begin
                    w_cand_nxt = r_s2;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_sw_out_nxt   = r_cand;
                    w_sw_valid_nxt = 1'b1;
                    w_state_nxt    = ST_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.sw_out   = r_sw_out;
    assign bus.sw_valid = r_sw_valid;
    assign bus.busy     = (r_state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debounce_filter
//  Description : Self-checking bench for sw_debounce_filter (WIDTH=3,
//                STABLE_CYCLES=8). Table-driven reset sequence, hand-written
//                corner-case sequences and a randomized run, all compared
//                against a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce_filter;

    localparam int WIDTH = 3;
    localparam int N     = 8;

    logic clk;
    logic rst;

    sw_debounce_filter_if #(.WIDTH(WIDTH)) bus ();

    sw_debounce_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sw_in reaches the filter two edges late; a code is
    // accepted once the filter has seen it on N+1 consecutive edges while
    // it differs from the accepted output.
    logic [WIDTH-1:0] m_s1, m_s2, m_prev, m_out;
    logic             m_valid, m_busy;
    int               m_run;

    // Scenario bookkeeping
    int  cyc;
    int  pulses;
    int  last_pulse;
    bit  seen_001;

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] sw_in;
        logic [WIDTH-1:0] e_out;
        logic             e_valid;
        logic             e_busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [WIDTH-1:0] in);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_out = '0;
            m_valid = 1'b0; m_busy = 1'b0; m_run = 0;
        end else begin
            if (m_run == 0 || m_s2 != m_prev) m_run = 1;
            else                              m_run = m_run + 1;
            m_prev  = m_s2;
            m_valid = 1'b0;
            if (m_s2 != m_out && m_run >= N + 1) begin
                m_out   = m_s2;
                m_valid = 1'b1;
            end
            m_busy = (m_s2 != m_out);
            m_s2   = m_s1;
            m_s1   = in;
        end
    endtask

    // One clock: drive, clock edge, advance model, compare.
    task automatic step(input logic r, input logic [WIDTH-1:0] in);
        rst       = r;
        bus.sw_in = in;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(r, in);
        chk("sw_out",   32'(bus.sw_out),   32'(m_out));
        chk("sw_valid", 32'(bus.sw_valid), 32'(m_valid));
        chk("busy",     32'(bus.busy),     32'(m_busy));
        if (bus.sw_valid === 1'b1) begin
            pulses++;
            last_pulse = cyc;
        end
        if (bus.sw_out === 3'b001) seen_001 = 1'b1;
    endtask

    task automatic hold(input logic [WIDTH-1:0] in, input int n);
        for (int k = 0; k < n; k++) step(1'b0, in);
    endtask

    task automatic clear_stats();
        pulses     = 0;
        last_pulse = -1;
        seen_001   = 1'b0;
    endtask

    int e0;
    logic [WIDTH-1:0] rin;
    int rlen;
    bit rrst;

    initial begin
        cyc = 0;
        clear_stats();
        model_edge(1'b1, '0);
        rst       = 1'b1;
        bus.sw_in = 3'b101;

        // ---- Reset with switches on: explicit cycle-by-cycle table ----
        tbl[0] = '{1'b1, 3'b101, 3'b000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 3'b101, 3'b000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 3'b101, 3'b000, 1'b0, 1'b0};  // E0
        tbl[3] = '{1'b0, 3'b101, 3'b000, 1'b0, 1'b0};  // E1
        for (int i = 4; i < 12; i++)                   // E2..E9
            tbl[i] = '{1'b0, 3'b101, 3'b000, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 3'b101, 3'b101, 1'b1, 1'b0}; // E10
        tbl[13] = '{1'b0, 3'b101, 3'b101, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].sw_in);
            chk("tbl_sw_out",   32'(bus.sw_out),   32'(tbl[i].e_out));
            chk("tbl_sw_valid", 32'(bus.sw_valid), 32'(tbl[i].e_valid));
            chk("tbl_busy",     32'(bus.busy),     32'(tbl[i].e_busy));
        end

        // Return to a stable 000
        hold(3'b000, 14);

        // ---- Clean step 000 -> 001 ----
        clear_stats();
        e0 = cyc + 1;
        hold(3'b001, 14);
        chk("clean_pulses",  32'(pulses),       32'd1);
        chk("clean_latency", 32'(last_pulse),   32'(e0 + 10));
        chk("clean_out",     32'(bus.sw_out),   32'(3'b001));

        // ---- Bounce burst then 010 ----
        hold(3'b000, 14);
        clear_stats();
        for (int p = 0; p < 4; p++) begin
            hold(3'b001, 3);
            hold(3'b000, 3);
        end
        e0 = cyc + 1;
        hold(3'b010, 14);
        chk("bounce_pulses",  32'(pulses),     32'd1);
        chk("bounce_latency", 32'(last_pulse), 32'(e0 + 10));
        chk("bounce_no_001",  32'(seen_001),   32'd0);
        chk("bounce_out",     32'(bus.sw_out), 32'(3'b010));

        // ---- Glitch back ----
        hold(3'b000, 14);
        clear_stats();
        hold(3'b001, 5);
        hold(3'b000, 10);
        chk("glitch_pulses", 32'(pulses),     32'd0);
        chk("glitch_out",    32'(bus.sw_out), 32'(3'b000));
        chk("glitch_busy",   32'(bus.busy),   32'd0);

        // ---- Mid-wait code change ----
        clear_stats();
        hold(3'b001, 4);
        e0 = cyc + 1;
        hold(3'b011, 14);
        chk("midwait_pulses",  32'(pulses),     32'd1);
        chk("midwait_latency", 32'(last_pulse), 32'(e0 + 10));
        chk("midwait_out",     32'(bus.sw_out), 32'(3'b011));

        // ---- Reset mid-operation ----
        clear_stats();
        hold(3'b100, 5);
        chk("midrst_busy_before", 32'(bus.busy), 32'd1);
        step(1'b1, 3'b100);
        chk("midrst_out",   32'(bus.sw_out),   32'd0);
        chk("midrst_valid", 32'(bus.sw_valid), 32'd0);
        chk("midrst_busy",  32'(bus.busy),     32'd0);
        clear_stats();
        e0 = cyc + 1;
        hold(3'b100, 14);
        chk("midrst_requal_pulses",  32'(pulses),     32'd1);
        chk("midrst_requal_latency", 32'(last_pulse), 32'(e0 + 10));
        chk("midrst_requal_out",     32'(bus.sw_out), 32'(3'b100));

        // ---- Randomized run against the model ----
        for (int s = 0; s < 300; s++) begin
            rin  = 3'($urandom_range(0, 7));
            rlen = $urandom_range(1, 14);
            rrst = ($urandom_range(0, 40) == 0);
            for (int j = 0; j < rlen; j++)
                step(rrst && (j == 0), rin);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_debounce_filter.md
# sw_debounce_filter

Upstream conditioning stage for the slide-switch bus that drives the board's switch-controlled LED state machine. Synchronizes the raw, asynchronous switch vector into the `clk` domain and applies a stability filter. The filtered vector only changes after the new value has been held unchanged for a programmable number of cycles. The block presents the clean vector on `sw_out` and a one-cycle `sw_valid` strobe whenever that vector changes, so the downstream FSM never sees bounce or transient codes.

## Interface
- `WIDTH`, 3: number of switch bits.
- `STABLE_CYCLES`, 1_000_000: cycles a new value must stay unchanged before acceptance (10 ms at 100 MHz). Must be ≥ 2. Counter width is `$clog2(STABLE_CYCLES)`.
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `sw_in`  in  WIDTH: raw switch pins, asynchronous to `clk`.
- `sw_out`  out  WIDTH: debounced switch vector, registered.
- `sw_valid`  out  1: high for exactly one cycle after each `sw_out` update.
- `busy`  out  1: high while a candidate value is being qualified (state WAIT).

## Operation
- **Synchronizer:** two flops, `s1 <= sw_in` and `s2 <= s1`. Only `s2` is used by the filter logic, and `s2` is reset to 0.
- **Filtering:** the whole vector is filtered as one unit, not per bit. A simultaneous multi-bit change is a single candidate.
- **Internal registers:** `state` (STABLE or WAIT), `cand[WIDTH]` and `cnt`.
- **STABLE:**
  - If `s2 == sw_out`, stay.
  - Otherwise go to WAIT with `cand <= s2` and `cnt <= 0`.
- **WAIT** evaluates in this priority order each edge:
  1. If `s2 == sw_out` (bounced back): go to STABLE. `sw_out` is unchanged and there is no strobe.
  2. Else if `s2 != cand` (new code): `cand <= s2`, `cnt <= 0`, stay in WAIT.
  3. Else if `cnt == STABLE_CYCLES-1`: `sw_out <= cand`, `sw_valid <= 1`, go to STABLE.
  4. Else `cnt <= cnt + 1`.
- `sw_valid` is 0 on every edge where rule 3 does not fire. It is never high for two consecutive cycles.
- `busy = (state == WAIT)`.
- **Reset:** all registers are cleared regardless of state, including mid-WAIT. `s1 = s2 = 0`, `sw_out = 0`, `sw_valid = 0`, `busy = 0`, `cand = 0`, `cnt = 0`, state = STABLE. A pending candidate is discarded without a strobe.
- **Switches already on at reset release:** they are treated as an ordinary change from 0 and qualify normally.
- **Counter:** never wraps. It is cleared on every candidate change and on entry to WAIT.

## Timing
- Let E0 be the first rising edge that samples a new `sw_in` value into `s1`, with the value held steady from then on.
  - E1: `s2` updates.
  - E2: state becomes WAIT, `cnt = 0`.
  - E2+N: `sw_out` updates (N = `STABLE_CYCLES`).
- Latency from E0 to `sw_out` update is therefore `STABLE_CYCLES + 2` edges.
- `sw_valid` is high in the cycle following the update edge and aligned with the first cycle that the new `sw_out` is visible.
- **Input held for fewer than N cycles:** no update and no strobe. `busy` drops on the edge after `s2` returns to `sw_out`.
- **Candidate change during WAIT:** the count restarts. Latency is measured from the last change.

## Test plan
All scenarios use `STABLE_CYCLES = 8` and `WIDTH = 3`.
- **Reset with switches on:** hold `rst` with `sw_in = 101`; all outputs are 0. Release `rst`, then `sw_out = 101` exactly 10 edges after the first post-reset sampling edge. `sw_valid` is high for 1 cycle and `busy` is high for the 8 cycles before the update.
- **Clean step:** from stable `000`, step `sw_in` to `001` and hold. `sw_out = 001` exactly 10 edges after E0, with one `sw_valid` pulse and no intermediate values.
- **Bounce burst:** toggle `sw_in` between `001` and `000` every 3 cycles for 24 cycles, then hold `010`. `sw_out` goes `000 → 010` directly, 10 edges after the final change. There is exactly one `sw_valid` pulse, and `001` never appears.
- **Glitch back:** from `000`, drive `001` for 5 cycles, then `000`. `sw_out` stays `000`, `sw_valid` is never asserted, and `busy` deasserts after the return.
- **Mid-wait code change:** drive `001` for 4 cycles, then `011` and hold. `sw_out` goes `000 → 011` 10 edges after the `011` change, with a single pulse.
- **Reset mid-operation:** assert `rst` for 1 cycle while `busy = 1`. On the next edge all outputs are 0 with no pulse. Qualification then restarts from `sw_out = 0`.
